// File: rtl/serial_adder.sv
// Multi-cycle adder: STEP bits per clock through a registered carry chain,
// with a busy/done handshake and a result held until the next request.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | adding STEP bits per edge, operands shifting right
// DONE  | one cycle, Sum/Cout/Ovf valid, done=1
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSTEP = WIDTH / STEP;
    localparam int CW    = $clog2(NSTEP + 1);

    generate
        if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_nxt;
    logic [WIDTH-1:0]       a_q, b_q;
    logic                   carry_q;
    logic [CW-1:0]          cnt_q;
    logic                   capture;
    logic                   last_step;
    logic [STEP:0]          step_add;
    logic                   msb_cin;
    logic [WIDTH+STEP-1:0]  sum_cat;

    assign last_step = (cnt_q == CW'(NSTEP - 1));
    assign step_add  = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]}
                     + {{STEP{1'b0}}, carry_q};
    // Carry into the slice's top bit, recovered from its sum bit.
    assign msb_cin   = step_add[STEP-1] ^ a_q[STEP-1] ^ b_q[STEP-1];
    assign sum_cat   = {step_add[STEP-1:0], Sum};

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else if (capture) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Ci;
            cnt_q   <= '0;
        end else if (busy) begin
            a_q     <= a_q >> STEP;
            b_q     <= b_q >> STEP;
            Sum     <= sum_cat[WIDTH+STEP-1:STEP];
            carry_q <= step_add[STEP];
            cnt_q   <= cnt_q + CW'(1);
            if (last_step) begin
                Cout <= step_add[STEP];
                Ovf  <= msb_cin ^ step_add[STEP];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four configurations checked every cycle against an
// arithmetic model, plus directed vectors with hand-computed results.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] st_v, civ_v;
    logic [7:0] av[4], bv[4];
    logic [3:0] busy_v, done_v, cout_v, ovf_v;
    logic [7:0] sum_a, sum_b;
    logic [3:0] sum_c, sum_d;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    int wv[4] = '{8, 8, 4, 4};
    int nv[4] = '{8, 2, 4, 2};

    int run_left[4];
    int exp_done[4], exp_sum[4], exp_cout[4], exp_ovf[4];
    int pend_sum[4], pend_cout[4], pend_ovf[4];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .STEP(1)) u_w8s1 (
        .clk(clk), .rst_n(rst_n), .start(st_v[0]), .A(av[0]), .B(bv[0]), .Ci(civ_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .Sum(sum_a), .Cout(cout_v[0]), .Ovf(ovf_v[0]));
    serial_adder #(.WIDTH(8), .STEP(4)) u_w8s4 (
        .clk(clk), .rst_n(rst_n), .start(st_v[1]), .A(av[1]), .B(bv[1]), .Ci(civ_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .Sum(sum_b), .Cout(cout_v[1]), .Ovf(ovf_v[1]));
    serial_adder #(.WIDTH(4), .STEP(1)) u_w4s1 (
        .clk(clk), .rst_n(rst_n), .start(st_v[2]), .A(av[2][3:0]), .B(bv[2][3:0]), .Ci(civ_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .Sum(sum_c), .Cout(cout_v[2]), .Ovf(ovf_v[2]));
    serial_adder #(.WIDTH(4), .STEP(2)) u_w4s2 (
        .clk(clk), .rst_n(rst_n), .start(st_v[3]), .A(av[3][3:0]), .B(bv[3][3:0]), .Ci(civ_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .Sum(sum_d), .Cout(cout_v[3]), .Ovf(ovf_v[3]));

    function automatic int sum_of(input int i);
        case (i)
            0:       return int'(sum_a);
            1:       return int'(sum_b);
            2:       return int'(sum_c);
            default: return int'(sum_d);
        endcase
    endfunction

    // Reference: plain integer addition, signed overflow from the true signed sum.
    function automatic void calc(input int w, input int a, input int b, input int ci,
                                 output int s, output int co, output int ov);
        int tot, sa, sb, ssum, lim;
        tot  = a + b + ci;
        s    = tot % (1 << w);
        co   = tot >> w;
        lim  = 1 << (w - 1);
        sa   = (a >= lim) ? a - (1 << w) : a;
        sb   = (b >= lim) ? b - (1 << w) : b;
        ssum = sa + sb + ci;
        ov   = (ssum >= lim || ssum < -lim) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a request is taken when not running; the result appears after NSTEP more edges.
    always @(posedge clk) begin
        int s, co, ov, mask;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                run_left[i] <= 0;
                exp_done[i] <= 0;
                exp_sum[i]  <= 0;
                exp_cout[i] <= 0;
                exp_ovf[i]  <= 0;
            end else if (run_left[i] > 0) begin
                run_left[i] <= run_left[i] - 1;
                if (run_left[i] == 1) begin
                    exp_done[i] <= 1;
                    exp_sum[i]  <= pend_sum[i];
                    exp_cout[i] <= pend_cout[i];
                    exp_ovf[i]  <= pend_ovf[i];
                end
            end else begin
                exp_done[i] <= 0;
                if (st_v[i]) begin
                    mask = (1 << wv[i]) - 1;
                    calc(wv[i], int'(av[i]) & mask, int'(bv[i]) & mask, int'(civ_v[i]), s, co, ov);
                    pend_sum[i]  <= s;
                    pend_cout[i] <= co;
                    pend_ovf[i]  <= ov;
                    run_left[i]  <= nv[i];
                end
            end
        end
        if (!rst_n) chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("u%0d busy", i), int'(busy_v[i]), (run_left[i] > 0) ? 1 : 0);
                chk($sformatf("u%0d done", i), int'(done_v[i]), exp_done[i]);
                if (run_left[i] == 0) begin
                    chk($sformatf("u%0d sum", i), sum_of(i), exp_sum[i]);
                    chk($sformatf("u%0d cout", i), int'(cout_v[i]), exp_cout[i]);
                    chk($sformatf("u%0d ovf", i), int'(ovf_v[i]), exp_ovf[i]);
                end
            end
        end
    end

    // lat counts edges from the capture edge (edge 1) to the edge before done is seen.
    task automatic run_op(input int i, input int a, input int b, input int ci,
                          output int s, output int co, output int ov,
                          output int lat, output int bcnt);
        @(negedge clk);
        st_v[i]   = 1'b1;
        av[i]     = 8'(a);
        bv[i]     = 8'(b);
        civ_v[i]  = ci[0];
        @(negedge clk);
        st_v[i] = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!done_v[i] && lat < 40) begin
            if (busy_v[i]) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done_v[i]) chk($sformatf("u%0d done timeout", i), 0, 1);
        s  = sum_of(i);
        co = int'(cout_v[i]);
        ov = int'(ovf_v[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, co, ov, lat, bcnt, dcnt, es, eco, eov;
        rst_n = 1'b0;
        st_v  = '0;
        civ_v = '0;
        for (int i = 0; i < 4; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy_v[0]), 0);
        chk("reset done", int'(done_v[0]), 0);
        chk("reset sum", int'(sum_a), 0);
        chk("reset cout", int'(cout_v[0]), 0);
        chk("reset ovf", int'(ovf_v[0]), 0);
        rst_n = 1'b1;

        run_op(0, 'h3C, 'h5A, 0, s, co, ov, lat, bcnt);
        chk("3C+5A sum", s, 'h96);
        chk("3C+5A cout", co, 0);
        chk("3C+5A ovf", ov, 1);
        chk("3C+5A latency", lat, 9);
        chk("3C+5A busy cycles", bcnt, 8);

        run_op(0, 'hFF, 'h01, 1, s, co, ov, lat, bcnt);
        chk("FF+01+1 sum", s, 'h01);
        chk("FF+01+1 cout", co, 1);
        chk("FF+01+1 ovf", ov, 0);

        run_op(0, 'h7F, 'h00, 1, s, co, ov, lat, bcnt);
        chk("7F+00+1 sum", s, 'h80);
        chk("7F+00+1 cout", co, 0);
        chk("7F+00+1 ovf", ov, 1);

        run_op(1, 'hF0, 'h10, 0, s, co, ov, lat, bcnt);
        chk("step4 sum", s, 'h00);
        chk("step4 cout", co, 1);
        chk("step4 ovf", ov, 0);
        chk("step4 latency", lat, 3);
        chk("step4 busy cycles", bcnt, 2);

        // start held high through RUN and into DONE
        @(negedge clk);
        st_v[0] = 1'b1; av[0] = 8'h12; bv[0] = 8'h34; civ_v[0] = 1'b0;
        @(negedge clk);
        av[0] = 8'hAA; bv[0] = 8'h55;
        lat = 1;
        while (!done_v[0] && lat < 40) begin @(negedge clk); lat++; end
        chk("held start first sum", sum_of(0), 'h46);
        chk("held start first latency", lat, 9);
        @(negedge clk);
        st_v[0] = 1'b0;
        lat = 1;
        while (!done_v[0] && lat < 40) begin @(negedge clk); lat++; end
        chk("back-to-back sum", sum_of(0), 'hFF);
        chk("back-to-back cout", int'(cout_v[0]), 0);
        chk("back-to-back ovf", int'(ovf_v[0]), 0);
        chk("back-to-back latency", lat, 9);

        // reset after three RUN steps
        @(negedge clk);
        st_v[0] = 1'b1; av[0] = 8'hC3; bv[0] = 8'h21; civ_v[0] = 1'b1;
        @(negedge clk);
        st_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", int'(busy_v[0]), 0);
        chk("abort done", int'(done_v[0]), 0);
        chk("abort sum", int'(sum_a), 0);
        chk("abort cout", int'(cout_v[0]), 0);
        chk("abort ovf", int'(ovf_v[0]), 0);
        dcnt = 0;
        repeat (15) begin @(negedge clk); if (done_v[0]) dcnt++; end
        chk("abort no done", dcnt, 0);
        run_op(0, 'h81, 'h81, 0, s, co, ov, lat, bcnt);
        chk("after abort sum", s, 'h02);
        chk("after abort cout", co, 1);
        chk("after abort ovf", ov, 1);

        // reset and start on the same edge
        @(negedge clk);
        rst_n = 1'b0; st_v[0] = 1'b1; av[0] = 8'h01; bv[0] = 8'h01;
        @(negedge clk);
        rst_n = 1'b1; st_v[0] = 1'b0;
        chk("reset+start busy", int'(busy_v[0]), 0);
        repeat (3) @(negedge clk);
        chk("reset+start still idle", int'(busy_v[0]), 0);

        for (int i = 2; i < 4; i++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        run_op(i, a, b, ci, s, co, ov, lat, bcnt);
                        calc(4, a, b, ci, es, eco, eov);
                        chk($sformatf("u%0d exh %0h+%0h+%0d", i, a, b, ci),
                            s * 4 + co * 2 + ov, es * 4 + eco * 2 + eov);
                    end
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
